control: RTL and testbench



---
 rtl/control.sv | 64 ++++++
 tb/tb_control.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/control.sv
// Radix-4 (modified Booth) iteration controller for the multdiv multiplier.
// Decodes the current 3-bit Booth window into adder-stage controls and runs
// a saturating 4-bit iteration counter that flags the last of 16 iterations.
module control (
    input  logic [2:0] in,
    output logic       aos,
    output logic       sm,
    output logic       nop,
    output logic       done,
    input  logic       clr,
    input  logic       clk,
    output logic [3:0] count
);

    localparam logic [3:0] LAST_ITER = 4'd15;

    logic [3:0] count_r;
    logic [2:0] decode_s;

    // Booth window to {nop, aos, sm}. Both zero-digit windows (000 and 111)
    // collapse onto the same +0 encoding so no negative-zero path exists.
    function automatic logic [2:0] booth_decode(input logic [2:0] window);
        logic [2:0] ctl;
        case (window)
            3'b000:  ctl = 3'b100;
            3'b001:  ctl = 3'b000;
            3'b010:  ctl = 3'b000;
            3'b011:  ctl = 3'b001;
            3'b100:  ctl = 3'b011;
            3'b101:  ctl = 3'b010;
            3'b110:  ctl = 3'b010;
            3'b111:  ctl = 3'b100;
            default: ctl = 3'b100;
        endcase
        return ctl;
    endfunction

    // Zero-latency decode of the current Booth window.
    always_comb begin
        decode_s = booth_decode(in);
        nop      = decode_s[2];
        aos      = decode_s[1];
        sm       = decode_s[0];
    end

    // Iteration counter: cleared asynchronously by clr, counts up once per
    // edge and saturates on the final iteration until the next clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count_r <= 4'd0;
        end else if (count_r != LAST_ITER) begin
            count_r <= count_r + 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // Completion flag decoded straight from the counter register.
    always_comb begin
        count = count_r;
        done  = (count_r == LAST_ITER);
    end

endmodule

// File: tb/tb_control.sv
// Self-checking bench for the Booth iteration controller: directed test-plan
// sequences followed by randomized windows and clears against a reference.
`timescale 1ns/1ps
module tb_control;

    logic [2:0] in;
    logic       aos;
    logic       sm;
    logic       nop;
    logic       done;
    logic       clr;
    logic       clk;
    logic [3:0] count;

    int checks = 0;
    int errors = 0;
    int model_count = 0;

    control dut (
        .in    (in),
        .aos   (aos),
        .sm    (sm),
        .nop   (nop),
        .done  (done),
        .clr   (clr),
        .clk   (clk),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: value of the Booth digit, then controls from its sign/magnitude.
    function automatic logic [2:0] ref_decode(input logic [2:0] w);
        int d;
        logic r_nop, r_aos, r_sm;
        d = (w[1] ? 1 : 0) + (w[0] ? 1 : 0) - (w[2] ? 2 : 0);
        r_nop = (d == 0);
        r_aos = (d < 0);
        r_sm  = (d == 2) || (d == -2);
        return {r_nop, r_aos, r_sm};
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_dec"}, {29'd0, nop, aos, sm}, {29'd0, ref_decode(in)});
        check({tag, "_count"}, {28'd0, count}, model_count);
        check({tag, "_done"}, {31'd0, done}, (model_count == 15) ? 1 : 0);
    endtask

    task automatic set_clr(input logic v);
        clr = v;
        if (v) model_count = 0;
    endtask

    task automatic tick;
        @(posedge clk);
        if (clr) model_count = 0;
        else if (model_count < 15) model_count = model_count + 1;
        #1;
    endtask

    initial begin
        in  = 3'd0;
        clr = 1'b0;
        #2;
        set_clr(1'b1);
        #1;
        check_all("reset");

        // Decode sweep with the counter running.
        @(negedge clk); #1;
        set_clr(1'b0);
        for (int i = 0; i < 8; i++) begin
            in = 3'(i);
            #1;
            check_all($sformatf("sweep%0d", i));
            tick();
        end

        // Count sequence from a fresh clear.
        @(negedge clk); #1;
        set_clr(1'b1);
        tick();
        set_clr(1'b0);
        for (int i = 1; i <= 15; i++) begin
            tick();
            check({$sformatf("seq%0d", i), "_count"}, {28'd0, count}, i);
            check({$sformatf("seq%0d", i), "_done"}, {31'd0, done}, (i == 15) ? 1 : 0);
        end

        // Saturation.
        for (int i = 0; i < 20; i++) begin
            tick();
            check_all("sat");
        end

        // Asynchronous clear mid-count.
        @(negedge clk); #1;
        set_clr(1'b1);
        tick();
        set_clr(1'b0);
        for (int i = 0; i < 7; i++) tick();
        check_all("pre_async");
        @(negedge clk); #1;
        set_clr(1'b1);
        #1;
        check({"async", "_count"}, {28'd0, count}, 0);
        check({"async", "_done"}, {31'd0, done}, 0);
        #1;
        set_clr(1'b0);
        tick();
        check({"async_rel", "_count"}, {28'd0, count}, 1);

        // Clear from the final iteration, then a fresh full run.
        for (int i = 0; i < 14; i++) tick();
        check_all("pre_done_clr");
        @(negedge clk); #1;
        set_clr(1'b1);
        #1;
        check_all("done_clr");
        tick();
        @(negedge clk); #1;
        set_clr(1'b0);
        for (int i = 0; i < 15; i++) begin
            tick();
            check_all("rerun");
        end
        check({"rerun_end", "_done"}, {31'd0, done}, 1);

        // Decode independence with clr held high.
        @(negedge clk); #1;
        set_clr(1'b1);
        for (int i = 0; i < 8; i++) begin
            in = 3'(i);
            #1;
            check_all($sformatf("indep%0d", i));
            tick();
            check_all("indep_edge");
        end

        // Randomized windows and occasional clears.
        for (int i = 0; i < 300; i++) begin
            int r;
            @(negedge clk); #1;
            in = 3'($urandom);
            r = $urandom_range(0, 15);
            if (r == 0) set_clr(1'b1);
            else if (clr && r < 8) set_clr(1'b0);
            #1;
            check_all("rand_mid");
            tick();
            check_all("rand_edge");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
